// File: rtl/regfile_dump.sv
// Register file with two registered read ports, write-to-read bypass and a
// snapshot dump engine that streams every register out over a valid/ready
// channel. All state advances on the falling edge of clock; reset is
// asynchronous and active-low.
module regfile_dump #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_en,
    input  logic [AW-1:0]    dr,
    input  logic [WIDTH-1:0] Wrdata,
    input  logic [AW-1:0]    ir1,
    input  logic [AW-1:0]    ir2,
    output logic [WIDTH-1:0] reg1val,
    output logic [WIDTH-1:0] reg2val,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [AW-1:0]    dump_addr,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Address range helpers; the extra bit keeps the compare correct when
    // DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] rf     [DEPTH];
    logic [WIDTH-1:0] shadow [DEPTH];
    logic [AW-1:0]    ptr;
    logic             write_ok;
    logic             beat_accept;
    logic             snap;
    logic [WIDTH-1:0] rd1_next;
    logic [WIDTH-1:0] rd2_next;

    // Qualify the write: out-of-range addresses and a hard-wired r0 drop it.
    always_comb begin
        write_ok = write_en
                   && ({1'b0, dr} < DEPTH_EXT)
                   && !((ZERO_R0 != 0) && (dr == '0));
    end

    // Handshake and snapshot strobes for the dump engine.
    always_comb begin
        beat_accept = (state == DUMP) && dump_ready;
        snap        = (state == IDLE) && dump_start;
    end

    // Read data selection: bypass an accepted write, otherwise the array,
    // with unmapped addresses and a hard-wired r0 reading as zero.
    always_comb begin
        rd1_next = '0;
        rd2_next = '0;
        if (write_ok && (dr == ir1)) begin
            rd1_next = Wrdata;
        end else if (({1'b0, ir1} < DEPTH_EXT) && !((ZERO_R0 != 0) && (ir1 == '0))) begin
            rd1_next = rf[ir1];
        end
        if (write_ok && (dr == ir2)) begin
            rd2_next = Wrdata;
        end else if (({1'b0, ir2} < DEPTH_EXT) && !((ZERO_R0 != 0) && (ir2 == '0))) begin
            rd2_next = rf[ir2];
        end
    end

    // Register array update.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (write_ok) begin
            rf[dr] <= Wrdata;
        end
    end

    // Registered read ports, one edge of latency.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            reg1val <= '0;
            reg2val <= '0;
        end else begin
            reg1val <= rd1_next;
            reg2val <= rd2_next;
        end
    end

    // Snapshot copy; nonblocking reads of rf capture the pre-write contents.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= rf[i];
            end
        end
    end

    // Dump FSM state register.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat pointer: cleared on a new dump, advanced on each accepted beat.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (snap) begin
            ptr <= '0;
        end else if (beat_accept) begin
            if (ptr == LAST_ADDR) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    // Dump FSM next-state logic; start requests outside IDLE are ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (dump_start) state_next = DUMP;
            DUMP: if (beat_accept && (ptr == LAST_ADDR)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Dump FSM outputs; the beat fields are zero whenever no beat is offered.
    always_comb begin
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        case (state)
            DUMP: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                dump_addr  = ptr;
                dump_data  = shadow[ptr];
            end
            DONE: dump_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a default instance (dut_a) and a
// DEPTH=6, ZERO_R0=1 instance (dut_b) share the same stimulus. Stimulus is
// driven 1 time unit after the rising edge, the DUT acts on the falling
// edge, and the monitor samples 2 units after the next rising edge.
module tb_regfile_dump;

    logic        clock;
    logic        reset;
    logic        write_en;
    logic [2:0]  dr;
    logic [15:0] wrdata;
    logic [2:0]  ir1;
    logic [2:0]  ir2;
    logic        dump_start;
    logic        dump_ready;

    logic [15:0] a_reg1val, a_reg2val, a_dump_data;
    logic [2:0]  a_dump_addr;
    logic        a_dump_valid, a_dump_busy, a_dump_done;
    logic [15:0] b_reg1val, b_reg2val, b_dump_data;
    logic [2:0]  b_dump_addr;
    logic        b_dump_valid, b_dump_busy, b_dump_done;

    regfile_dump #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0)) dut_a (
        .clock(clock), .reset(reset), .write_en(write_en), .dr(dr), .Wrdata(wrdata),
        .ir1(ir1), .ir2(ir2), .reg1val(a_reg1val), .reg2val(a_reg2val),
        .dump_start(dump_start), .dump_valid(a_dump_valid), .dump_ready(dump_ready),
        .dump_addr(a_dump_addr), .dump_data(a_dump_data), .dump_busy(a_dump_busy),
        .dump_done(a_dump_done)
    );

    regfile_dump #(.WIDTH(16), .DEPTH(6), .ZERO_R0(1)) dut_b (
        .clock(clock), .reset(reset), .write_en(write_en), .dr(dr), .Wrdata(wrdata),
        .ir1(ir1), .ir2(ir2), .reg1val(b_reg1val), .reg2val(b_reg2val),
        .dump_start(dump_start), .dump_valid(b_dump_valid), .dump_ready(dump_ready),
        .dump_addr(b_dump_addr), .dump_data(b_dump_data), .dump_busy(b_dump_busy),
        .dump_done(b_dump_done)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
    } rd_item_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } beat_item_t;

    rd_item_t   rd_q[$];
    beat_item_t beat_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int nc           = 0;
    int done_count   = 0;

    logic        stall_flag = 1'b0;
    logic [2:0]  stall_addr;
    logic [15:0] stall_data;

    // Falling edge clock: the DUT's active edge is at t=5, 15, 25, ...
    initial clock = 1'b1;
    always #5 clock = ~clock;

    // Count active edges so expectations can be scheduled against them.
    always @(negedge clock) nc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [2:0] d_addr, input logic [15:0] d,
                                  input logic [2:0] a1, input logic [2:0] a2,
                                  input logic start, input logic ready);
        @(posedge clock);
        #1;
        write_en   = we;
        dr         = d_addr;
        wrdata     = d;
        ir1        = a1;
        ir2        = a2;
        dump_start = start;
        dump_ready = ready;
    endtask

    task automatic expect_reads(input logic [15:0] a1, input logic [15:0] a2,
                                input logic [15:0] b1, input logic [15:0] b2);
        rd_item_t it;
        it.due = nc + 1;
        it.sel = 0; it.exp = a1; rd_q.push_back(it);
        it.sel = 1; it.exp = a2; rd_q.push_back(it);
        it.sel = 2; it.exp = b1; rd_q.push_back(it);
        it.sel = 3; it.exp = b2; rd_q.push_back(it);
    endtask

    task automatic expect_beat(input logic [2:0] addr, input logic [15:0] data);
        beat_item_t b;
        b.addr = addr;
        b.data = data;
        beat_q.push_back(b);
    endtask

    function automatic logic [15:0] read_actual(input int sel);
        case (sel)
            0: return a_reg1val;
            1: return a_reg2val;
            2: return b_reg1val;
            default: return b_reg2val;
        endcase
    endfunction

    // Monitor: retires due read expectations, checks dump beats on
    // acceptance, checks stall stability and counts done pulses.
    always @(posedge clock) begin
        #2;
        while (rd_q.size() > 0 && rd_q[0].due <= nc) begin
            rd_item_t it;
            it = rd_q.pop_front();
            check_output($sformatf("read edge%0d sel%0d", it.due, it.sel), 64'(read_actual(it.sel)), 64'(it.exp));
        end
        if (a_dump_valid) begin
            if (stall_flag) begin
                check_output("stall addr hold", 64'(a_dump_addr), 64'(stall_addr));
                check_output("stall data hold", 64'(a_dump_data), 64'(stall_data));
            end
            if (dump_ready) begin
                stall_flag = 1'b0;
                if (beat_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected beat: got addr %0d data %h expected no beat", a_dump_addr, a_dump_data);
                end else begin
                    beat_item_t b;
                    b = beat_q.pop_front();
                    check_output($sformatf("beat%0d addr", b.addr), 64'(a_dump_addr), 64'(b.addr));
                    check_output($sformatf("beat%0d data", b.addr), 64'(a_dump_data), 64'(b.data));
                end
            end else begin
                stall_flag = 1'b1;
                stall_addr = a_dump_addr;
                stall_data = a_dump_data;
            end
        end else begin
            stall_flag = 1'b0;
        end
        if (a_dump_done) begin
            done_count++;
            check_output("valid low with done", 64'(a_dump_valid), 64'(0));
        end
    end

    initial begin
        reset      = 1'b0;
        write_en   = 1'b0;
        dr         = '0;
        wrdata     = '0;
        ir1        = '0;
        ir2        = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;

        #1;
        check_output("reset reg1val", 64'(a_reg1val), 64'(0));
        check_output("reset reg2val", 64'(a_reg2val), 64'(0));
        check_output("reset dump_valid", 64'(a_dump_valid), 64'(0));
        check_output("reset dump_busy", 64'(a_dump_busy), 64'(0));
        check_output("reset dump_done", 64'(a_dump_done), 64'(0));

        @(posedge clock);
        #1;
        reset = 1'b1;

        // Basic write/read, bypass, r0 handling and out-of-range addresses.
        apply_stimulus(1, 3, 16'h1234, 0, 0, 0, 0); expect_reads(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        apply_stimulus(0, 0, 16'h0000, 3, 0, 0, 0); expect_reads(16'h1234, 16'h0000, 16'h1234, 16'h0000);
        apply_stimulus(1, 5, 16'hBEEF, 3, 5, 0, 0); expect_reads(16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF);
        apply_stimulus(1, 0, 16'hFFFF, 0, 5, 0, 0); expect_reads(16'hFFFF, 16'hBEEF, 16'h0000, 16'hBEEF);
        apply_stimulus(0, 0, 16'h0000, 0, 0, 0, 0); expect_reads(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
        apply_stimulus(1, 7, 16'h7777, 7, 3, 0, 0); expect_reads(16'h7777, 16'h1234, 16'h0000, 16'h1234);
        apply_stimulus(1, 6, 16'h6666, 6, 7, 0, 0); expect_reads(16'h6666, 16'h7777, 16'h0000, 16'h0000);
        apply_stimulus(0, 0, 16'h0000, 6, 7, 0, 0); expect_reads(16'h6666, 16'h7777, 16'h0000, 16'h0000);
        apply_stimulus(1, 1, 16'h1111, 3, 5, 0, 0); expect_reads(16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF);
        apply_stimulus(1, 2, 16'h2222, 1, 0, 0, 0); expect_reads(16'h1111, 16'hFFFF, 16'h1111, 16'h0000);
        apply_stimulus(1, 4, 16'h4444, 2, 4, 0, 0); expect_reads(16'h2222, 16'h4444, 16'h2222, 16'h4444);

        // Dump with a simultaneous write to r2: beat 2 carries the old value.
        apply_stimulus(1, 2, 16'hAAAA, 2, 4, 1, 0); expect_reads(16'hAAAA, 16'h4444, 16'hAAAA, 16'h4444);
        expect_beat(0, 16'hFFFF); expect_beat(1, 16'h1111);
        expect_beat(2, 16'h2222); expect_beat(3, 16'h1234);
        expect_beat(4, 16'h4444); expect_beat(5, 16'hBEEF);
        expect_beat(6, 16'h6666); expect_beat(7, 16'h7777);
        for (int i = 0; i < 40 && done_count == 0; i++) begin
            apply_stimulus(0, 0, 16'h0000, 2, 0, (i < 2), (i % 2 == 0));
            expect_reads(16'hAAAA, 16'hFFFF, 16'hAAAA, 16'h0000);
        end
        if (done_count == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL dump1 timeout: got no done pulse expected one within 40 edges");
        end
        repeat (3) apply_stimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        check_output("dump1 done pulses", 64'(done_count), 64'(1));
        check_output("dump1 beats left", 64'(beat_q.size()), 64'(0));

        // Dump aborted by reset while beat 4 is on offer.
        apply_stimulus(0, 0, 16'h0000, 0, 0, 1, 0); expect_reads(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
        expect_beat(0, 16'hFFFF); expect_beat(1, 16'h1111);
        expect_beat(2, 16'hAAAA); expect_beat(3, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 16'h0000, 0, 0, 0, 1);
            expect_reads(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
        end
        apply_stimulus(0, 0, 16'h0000, 0, 0, 0, 0); expect_reads(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
        @(posedge clock);
        #3;
        check_output("pre-abort dump_addr", 64'(a_dump_addr), 64'(4));
        reset = 1'b0;
        #1;
        check_output("abort dump_valid", 64'(a_dump_valid), 64'(0));
        check_output("abort dump_busy", 64'(a_dump_busy), 64'(0));
        check_output("abort dump_addr", 64'(a_dump_addr), 64'(0));
        check_output("abort dump_data", 64'(a_dump_data), 64'(0));
        check_output("abort reg1val", 64'(a_reg1val), 64'(0));
        repeat (3) @(posedge clock);
        check_output("abort dump_done count", 64'(done_count), 64'(1));
        check_output("abort beats left", 64'(beat_q.size()), 64'(0));
        #1;
        reset = 1'b1;

        // Normal operation after reset: file cleared, writes and bypass work.
        apply_stimulus(1, 1, 16'h5A5A, 3, 1, 0, 0); expect_reads(16'h0000, 16'h5A5A, 16'h0000, 16'h5A5A);
        apply_stimulus(0, 0, 16'h0000, 1, 3, 0, 0); expect_reads(16'h5A5A, 16'h0000, 16'h5A5A, 16'h0000);
        repeat (2) apply_stimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        @(posedge clock);
        #4;
        check_output("final done count", 64'(done_count), 64'(1));
        check_output("final reads left", 64'(rd_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
